// File: rtl/ws2812_rx_pkg.sv
// Shared WS2812 line definitions: receiver FSM states, pixel width, default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ws2812_rx_pkg;

  // Receiver line-tracking states
  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,  // waiting for a full latch gap before trusting the line
    ST_LOW    = 2'd1,  // line low between bits
    ST_HIGH   = 2'd2   // measuring a high pulse
  } rx_state_e;

  // GRB colour word width
  localparam int PIX_W = 24;

  // Default timing, in core clock samples; the LED-strip transmitter uses the same values
  localparam int WS_BIT_THRESH_CLK = 6;
  localparam int WS_MIN_HIGH_CLK   = 2;
  localparam int WS_MAX_HIGH_CLK   = 20;
  localparam int WS_RESET_LOW_CLK  = 500;
  localparam int WS_MAX_PIXELS     = 109;

endpackage

// File: rtl/ws2812_rx_pulse_meter.sv
// Synchronizes the serial line and measures high/low run lengths with saturating counters.
// Latency: din -> din_s 2 clk; edges and counts reflect din_s in the same cycle.
// Backpressure: none, free-running measurement.
module pulse_meter
  import ws2812_rx_pkg::*;
#(
  parameter int HI_MAX = WS_MAX_HIGH_CLK,
  parameter int LO_MAX = WS_RESET_LOW_CLK,
  parameter int HI_W   = $clog2(HI_MAX + 1),
  parameter int LO_W   = $clog2(LO_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            din,
  output logic            rise,
  output logic            fall,
  output logic [HI_W-1:0] hi_cnt,   // high run length including current sample
  output logic [HI_W-1:0] hi_len,   // high run length ending last cycle (pulse width on fall)
  output logic [LO_W-1:0] lo_cnt    // low run length including current sample
);

  localparam logic [HI_W-1:0] HI_SAT = HI_W'(HI_MAX);
  localparam logic [LO_W-1:0] LO_SAT = LO_W'(LO_MAX);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;  // din_s
  logic            prev_q, prev_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic [LO_W-1:0] lo_q, lo_d;

  // Next-state: two-stage synchronizer, edge history, saturating run counters
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    hi_d    = '0;
    lo_d    = '0;
    if (sync2_q) begin
      hi_d = (hi_q == HI_SAT) ? hi_q : hi_q + 1'b1;
    end else begin
      lo_d = (lo_q == LO_SAT) ? lo_q : lo_q + 1'b1;
    end
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign rise   = sync2_q & ~prev_q;
  assign fall   = ~sync2_q & prev_q;
  assign hi_cnt = hi_d;
  assign hi_len = hi_q;
  assign lo_cnt = lo_d;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes pulse widths into GRB pixels and frames, flags line errors.
// Latency: pix_valid 1 clk after the synchronized falling edge of bit 24 (3 clk after din falls).
// Backpressure: none; pixels are strobed once and outputs held until the next pixel.
module ws2812_rx
  import ws2812_rx_pkg::*;
#(
  parameter int BIT_THRESH_CLK = WS_BIT_THRESH_CLK,
  parameter int MIN_HIGH_CLK   = WS_MIN_HIGH_CLK,
  parameter int MAX_HIGH_CLK   = WS_MAX_HIGH_CLK,
  parameter int RESET_LOW_CLK  = WS_RESET_LOW_CLK,
  parameter int MAX_PIXELS     = WS_MAX_PIXELS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic             pix_valid,
  output logic [7:0]       pix_index,
  output logic [PIX_W-1:0] pix_grb,
  output logic             frame_done,
  output logic [7:0]       frame_pixels,
  output logic             err_glitch,
  output logic             err_stuck,
  output logic             err_overflow
);

  localparam int HI_W  = $clog2(MAX_HIGH_CLK + 1);
  localparam int LO_W  = $clog2(RESET_LOW_CLK + 1);
  localparam int BIT_W = $clog2(PIX_W);
  // A single-sample high is never a real bit, whatever MIN_HIGH_CLK says
  localparam int GLITCH_LT = (MIN_HIGH_CLK < 2) ? 2 : MIN_HIGH_CLK;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PIX_W - 1);

  logic            rise, fall;
  logic [HI_W-1:0] hi_cnt, hi_len;
  logic [LO_W-1:0] lo_cnt;

  pulse_meter #(
    .HI_MAX (MAX_HIGH_CLK),
    .LO_MAX (RESET_LOW_CLK),
    .HI_W   (HI_W),
    .LO_W   (LO_W)
  ) u_meter (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .rise   (rise),
    .fall   (fall),
    .hi_cnt (hi_cnt),
    .hi_len (hi_len),
    .lo_cnt (lo_cnt)
  );

  rx_state_e        state_q, state_d;
  logic [PIX_W-2:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       pix_cnt_q, pix_cnt_d;
  logic             pix_valid_q, pix_valid_d;
  logic [7:0]       pix_index_q, pix_index_d;
  logic [PIX_W-1:0] pix_grb_q, pix_grb_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       frame_pixels_q, frame_pixels_d;
  logic             err_glitch_q, err_glitch_d;
  logic             err_stuck_q, err_stuck_d;
  logic             err_overflow_q, err_overflow_d;

  logic             gap_seen, stuck, is_glitch, bit_val;
  logic [PIX_W-1:0] shifted;
  logic [7:0]       pix_cnt_inc;

  // Pulse classification and assembled word candidates
  always_comb begin
    gap_seen    = int'(lo_cnt) >= RESET_LOW_CLK;
    stuck       = int'(hi_cnt) >= MAX_HIGH_CLK;
    is_glitch   = int'(hi_len) < GLITCH_LT;
    bit_val     = int'(hi_len) >= BIT_THRESH_CLK;
    shifted     = {shift_q, bit_val};
    pix_cnt_inc = (pix_cnt_q == 8'hFF) ? pix_cnt_q : pix_cnt_q + 8'd1;
  end

  // Next-state and output logic of the line FSM
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    pix_cnt_d      = pix_cnt_q;
    pix_valid_d    = 1'b0;
    pix_index_d    = pix_index_q;
    pix_grb_d      = pix_grb_q;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;
    err_glitch_d   = 1'b0;
    err_stuck_d    = 1'b0;
    // overflow stays visible through the frame_done cycle, then clears
    err_overflow_d = frame_done_q ? 1'b0 : err_overflow_q;
    case (state_q)
      ST_RESYNC: begin
        if (gap_seen) begin
          state_d   = ST_LOW;
          shift_d   = '0;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
        end else if (gap_seen && (pix_cnt_q != '0 || bit_cnt_q != '0)) begin
          frame_done_d   = 1'b1;
          frame_pixels_d = pix_cnt_q;
          shift_d        = '0;
          bit_cnt_d      = '0;
          pix_cnt_d      = '0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          if (is_glitch) begin
            err_glitch_d = 1'b1;
          end else if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            pix_cnt_d = pix_cnt_inc;
            if (int'(pix_cnt_q) < MAX_PIXELS) begin
              pix_valid_d = 1'b1;
              pix_index_d = pix_cnt_q;
              pix_grb_d   = shifted;
            end else begin
              err_overflow_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shifted[PIX_W-2:0];
          end
        end else if (stuck) begin
          // stuck line poisons the whole frame; wait for a clean gap
          err_stuck_d = 1'b1;
          state_d     = ST_RESYNC;
          shift_d     = '0;
          bit_cnt_d   = '0;
          pix_cnt_d   = '0;
        end
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RESYNC;
    else        state_q <= state_d;
  end

  // Assembly counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      pix_cnt_q      <= '0;
      pix_valid_q    <= 1'b0;
      pix_index_q    <= '0;
      pix_grb_q      <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      err_glitch_q   <= 1'b0;
      err_stuck_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      pix_cnt_q      <= pix_cnt_d;
      pix_valid_q    <= pix_valid_d;
      pix_index_q    <= pix_index_d;
      pix_grb_q      <= pix_grb_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      err_glitch_q   <= err_glitch_d;
      err_stuck_q    <= err_stuck_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_index    = pix_index_q;
  assign pix_grb      = pix_grb_q;
  assign frame_done   = frame_done_q;
  assign frame_pixels = frame_pixels_q;
  assign err_glitch   = err_glitch_q;
  assign err_stuck    = err_stuck_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter BIT_THRESH_CLK, default 6: high-pulse length (synchronized clk samples) at or above which a bit decodes as 1.
REQ-002 Parameter MIN_HIGH_CLK, default 2: high pulses shorter than this are glitches.
REQ-003 Parameter MAX_HIGH_CLK, default 20: high pulse reaching this length is a stuck-line error.
REQ-004 Parameter RESET_LOW_CLK, default 500: low time marking the WS2812 latch/reset gap.
REQ-005 Parameter MAX_PIXELS, default 109: pixels accepted per frame.
REQ-006 clk  input  1  system clock, single clock domain.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 din  input  1  asynchronous WS2812 serial line (idle low).
REQ-009 pix_valid  output  1  one-cycle strobe, pixel decoded.
REQ-010 pix_index  output  8  pixel position in frame, 0-based.
REQ-011 pix_grb  output  24  decoded colour, G[23:16] R[15:8] B[7:0].
REQ-012 frame_done  output  1  one-cycle strobe on latch gap after a non-empty frame.
REQ-013 frame_pixels  output  8  pixels received in the completed frame, saturates at 255.
REQ-014 err_glitch  output  1  one-cycle strobe, pulse shorter than MIN_HIGH_CLK discarded.
REQ-015 err_stuck  output  1  one-cycle strobe, high pulse reached MAX_HIGH_CLK.
REQ-016 err_overflow  output  1  sticky until next frame_done; pixel beyond MAX_PIXELS received.

Function
REQ-017 din SHALL pass a two-flop synchronizer; din_s (second flop) drives all logic; din->din_s latency 2 clk.
REQ-018 FSM states SHALL be RESYNC, LOW, HIGH; reset state RESYNC.
REQ-019 RESYNC: count consecutive din_s=0 cycles, clear on din_s=1; at RESET_LOW_CLK go LOW with pixel and bit counters 0, no frame_done.
REQ-020 LOW: din_s=1 SHALL go HIGH with high counter =1; low counter reaching RESET_LOW_CLK with pixel or bit count nonzero SHALL pulse frame_done once, discard partial bits, clear counters.
REQ-021 HIGH: count high cycles; on din_s=0 classify: count<MIN_HIGH_CLK -> err_glitch, bit dropped; count>=BIT_THRESH_CLK -> 1; else 0; return to LOW, low counter =1.
REQ-022 HIGH count reaching MAX_HIGH_CLK SHALL pulse err_stuck, discard partial pixel, go RESYNC (frame not completed).
REQ-023 Bits SHALL shift MSB-first; the 24th bit completes a pixel.
REQ-024 pix_valid SHALL assert the cycle after the din_s falling edge completing bit 24, with pix_grb/pix_index held stable until the next pix_valid.
REQ-025 pix_index SHALL increment after each pixel; index >= MAX_PIXELS SHALL suppress pix_valid and set err_overflow.
REQ-026 frame_pixels SHALL update in the frame_done cycle; counts include overflow pixels.
REQ-027 All counters SHALL saturate, never wrap; width = clog2(max value+1).
REQ-028 A single-cycle high classifies as glitch even if MIN_HIGH_CLK<=1 is misconfigured never below 1.

Reset
REQ-029 rst_n low SHALL asynchronously clear synchronizer, counters, shift register; all outputs 0; state RESYNC.
REQ-030 Reset mid-frame SHALL discard everything; after release, decoding resumes only after a full RESET_LOW_CLK low gap.

Structure
REQ-031 Shared package holds state enum, pixel-colour width 24, default timing constants shared with the LED-strip transmitter.
REQ-032 One sub-module: pulse_meter (synchronizer, edge detect, saturating high/low counters); FSM and assembly in ws2812_rx.

Verification (BIT_THRESH_CLK=6, MIN_HIGH_CLK=2, MAX_HIGH_CLK=20, RESET_LOW_CLK=30, MAX_PIXELS=4)
REQ-033 Low 30 cycles, then 24 bits (1: 8H/4L, 0: 4H/8L) of 0xFF0080, low 30 -> pix_valid once, pix_index 0, pix_grb 0xFF0080, frame_done, frame_pixels 1.
REQ-034 Three pixels 0x000001,0x800000,0x5A5A5A then gap -> indices 0,1,2 in order, frame_pixels 3, no errors.
REQ-035 1-cycle high inserted between bits -> err_glitch once, decoded pixel unchanged.
REQ-036 din held high 25 cycles mid-pixel -> err_stuck at count 20, no pix_valid, no frame_done until 30-low gap plus new frame.
REQ-037 Six pixels then gap -> pix_valid 4 times, err_overflow set, frame_pixels 6, err_overflow clear after frame_done cycle.
REQ-038 rst_n low for 3 cycles after 12 bits -> outputs 0; following 24 bits without preceding 30-low gap ignored.
